ov5642_sccb_config: RTL and testbench

Power-up configuration sequencer for the OV5642 camera. It walks a register table and issues SCCB 3-phase-write transactions (device ID, address high byte, address low byte, data) over SIOC/SIOD, with inline millisecond delay entries. It runs once per `start` and raises `done` when the sensor is configured. After that the parallel pixel capture path can be trusted to receive valid frames.

---
 rtl/ov5642_pkg.sv | 48 ++++
 rtl/ov5642_config_rom.sv | 35 +++
 rtl/ov5642_sccb_config.sv | 227 ++++++++++++++++++++++
 tb/tb_ov5642_sccb_config.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov5642_pkg.sv
// Shared types for the OV5642 SCCB bring-up sequencer: table entry layout, delay marker, FSM states.
// Latency: n/a (declarations only); backpressure: none.
package ov5642_pkg;

    localparam int MAX_ENTRIES = 256;
    localparam int ENTRY_W     = 24;
    localparam logic [15:0] DELAY_MARK = 16'hFFFF;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_SHIFT,
        S_STOP,
        S_GAP,
        S_DELAY,
        S_NEXT
    } state_t;

    // Unused tail slots are zero-length delays, so any TABLE_LEN walks harmlessly.
    function automatic logic [MAX_ENTRIES*ENTRY_W-1:0] default_table();
        logic [MAX_ENTRIES*ENTRY_W-1:0] t;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            t[i*ENTRY_W +: ENTRY_W] = {DELAY_MARK, 8'h00};
        end
        t[0*ENTRY_W  +: ENTRY_W] = {16'h3103, 8'h93};
        t[1*ENTRY_W  +: ENTRY_W] = {16'h3008, 8'h82};
        t[2*ENTRY_W  +: ENTRY_W] = {DELAY_MARK, 8'h05};
        t[3*ENTRY_W  +: ENTRY_W] = {16'h3008, 8'h42};
        t[4*ENTRY_W  +: ENTRY_W] = {16'h3017, 8'h7F};
        t[5*ENTRY_W  +: ENTRY_W] = {16'h3018, 8'hFC};
        t[6*ENTRY_W  +: ENTRY_W] = {16'h3810, 8'hC2};
        t[7*ENTRY_W  +: ENTRY_W] = {16'h3615, 8'hF0};
        t[8*ENTRY_W  +: ENTRY_W] = {16'h3000, 8'h00};
        t[9*ENTRY_W  +: ENTRY_W] = {16'h3001, 8'h00};
        t[10*ENTRY_W +: ENTRY_W] = {16'h3002, 8'h00};
        t[11*ENTRY_W +: ENTRY_W] = {16'h3003, 8'h00};
        t[12*ENTRY_W +: ENTRY_W] = {16'h3008, 8'h02};
        return t;
    endfunction

endpackage

// File: rtl/ov5642_config_rom.sv
// Register-table ROM: index in, {addr16, data8} entry out.
// Latency: 1 cycle (registered output); backpressure: none.
module ov5642_config_rom
    import ov5642_pkg::*;
#(
    parameter int unsigned                     TABLE_LEN  = 64,
    parameter logic [MAX_ENTRIES*ENTRY_W-1:0]  TABLE_INIT = default_table()
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    output entry_t     entry
);

    entry_t entry_d;
    entry_t entry_q;

    always_comb begin
        entry_d = '{addr: DELAY_MARK, data: 8'h00};
        if (32'(addr) < TABLE_LEN) begin
            entry_d = TABLE_INIT[int'(addr)*ENTRY_W +: ENTRY_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/ov5642_sccb_config.sv
// OV5642 power-up sequencer: walks the ROM table issuing SCCB 3-phase writes and ms delays, once per start.
// Latency: 2 + 153*Q cycles per write entry; backpressure: none, start ignored unless idle.
module ov5642_sccb_config
    import ov5642_pkg::*;
#(
    parameter int unsigned                     CLK_FREQ_HZ  = 100_000_000,
    parameter int unsigned                     SCCB_FREQ_HZ = 100_000,
    parameter logic [7:0]                      DEV_ADDR     = 8'h78,
    parameter int unsigned                     TABLE_LEN    = 64,
    parameter logic [MAX_ENTRIES*ENTRY_W-1:0]  TABLE_INIT   = default_table()
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] index,
    output logic       sioc,
    output logic       siod_oe
);

    localparam int unsigned QUARTER = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
    localparam logic [31:0] Q_LAST   = 32'(QUARTER - 32'd1);
    localparam logic [31:0] MS_LAST  = 32'(CLK_FREQ_HZ / 1000 - 1);
    localparam logic [7:0]  LAST_IDX = 8'(TABLE_LEN - 1);

    if (QUARTER == 0 || TABLE_LEN == 0 || TABLE_LEN > MAX_ENTRIES) begin : g_bad_params
        $error("ov5642_sccb_config: quarter period is zero or TABLE_LEN out of 1..256");
    end

    state_t      state_q, state_d;
    logic [31:0] qcnt_q, qcnt_d;
    logic [1:0]  quar_q, quar_d;
    logic [3:0]  bit_q, bit_d;
    logic [1:0]  phase_q, phase_d;
    logic [35:0] shift_q, shift_d;
    logic [31:0] ms_cnt_q, ms_cnt_d;
    logic [7:0]  ms_left_q, ms_left_d;
    logic [7:0]  index_q, index_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        sioc_q, sioc_d;
    logic        siod_oe_q, siod_oe_d;
    logic        q_tick;
    entry_t      rom_entry;

    ov5642_config_rom #(
        .TABLE_LEN  (TABLE_LEN),
        .TABLE_INIT (TABLE_INIT)
    ) u_rom (
        .clk   (clk),
        .rst   (rst),
        .addr  (index_q),
        .entry (rom_entry)
    );

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        quar_d    = quar_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        shift_d   = shift_q;
        ms_cnt_d  = ms_cnt_q;
        ms_left_d = ms_left_q;
        index_d   = index_q;
        busy_d    = busy_q;
        done_d    = done_q;
        q_tick    = (qcnt_q == Q_LAST);

        if (state_q inside {S_START, S_SHIFT, S_STOP, S_GAP}) begin
            qcnt_d = q_tick ? '0 : qcnt_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    index_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                qcnt_d   = '0;
                quar_d   = '0;
                bit_d    = '0;
                phase_d  = '0;
                ms_cnt_d = '0;
                if (rom_entry.addr == DELAY_MARK) begin
                    ms_left_d = rom_entry.data;
                    state_d   = (rom_entry.data == 8'd0) ? S_NEXT : S_DELAY;
                end else begin
                    // Ninth bit of each phase is a 1 so the line is released for the ACK slot.
                    shift_d = {DEV_ADDR, 1'b1, rom_entry.addr[15:8], 1'b1,
                               rom_entry.addr[7:0], 1'b1, rom_entry.data, 1'b1};
                    state_d = S_START;
                end
            end
            S_START: begin
                if (q_tick) begin
                    quar_d = quar_q + 2'd1;
                    if (quar_q == 2'd1) begin
                        quar_d  = '0;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (q_tick) begin
                    quar_d = quar_q + 2'd1;
                    if (quar_q == 2'd3) begin
                        shift_d = {shift_q[34:0], 1'b1};
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd8) begin
                            bit_d   = '0;
                            phase_d = phase_q + 2'd1;
                            if (phase_q == 2'd3) begin
                                state_d = S_STOP;
                            end
                        end
                    end
                end
            end
            S_STOP: begin
                if (q_tick) begin
                    quar_d = quar_q + 2'd1;
                    if (quar_q == 2'd2) begin
                        quar_d  = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (q_tick) begin
                    quar_d = quar_q + 2'd1;
                    if (quar_q == 2'd3) begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_DELAY: begin
                ms_cnt_d = ms_cnt_q + 32'd1;
                if (ms_cnt_q == MS_LAST) begin
                    ms_cnt_d  = '0;
                    ms_left_d = ms_left_q - 8'd1;
                    if (ms_left_q == 8'd1) begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (index_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    index_d = index_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion is flagged on entry to the final NEXT so done and busy swap on one edge.
        if (state_d == S_NEXT && index_q == LAST_IDX) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        sioc_d    = 1'b1;
        siod_oe_d = 1'b0;
        case (state_d)
            S_START: begin
                sioc_d    = (quar_d == 2'd0);
                siod_oe_d = 1'b1;
            end
            S_SHIFT: begin
                sioc_d    = quar_d[1];
                siod_oe_d = ~shift_d[35];
            end
            S_STOP: begin
                sioc_d    = (quar_d != 2'd0);
                siod_oe_d = (quar_d != 2'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            quar_q    <= '0;
            bit_q     <= '0;
            phase_q   <= '0;
            shift_q   <= '0;
            ms_cnt_q  <= '0;
            ms_left_q <= '0;
            index_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sioc_q    <= 1'b1;
            siod_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            quar_q    <= quar_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            shift_q   <= shift_d;
            ms_cnt_q  <= ms_cnt_d;
            ms_left_q <= ms_left_d;
            index_q   <= index_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sioc_q    <= sioc_d;
            siod_oe_q <= siod_oe_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign index   = index_q;
    assign sioc    = sioc_q;
    assign siod_oe = siod_oe_q;

endmodule

// File: tb/tb_ov5642_sccb_config.sv
// Bench for ov5642_sccb_config: three table variants, an SCCB bus decoder and a transaction-level model.
module tb_ov5642_sccb_config;

    localparam int unsigned CLK_HZ  = 4_000_000;
    localparam int unsigned SCCB_HZ = 100_000;
    localparam int Q  = CLK_HZ / (4 * SCCB_HZ);
    localparam int MS = CLK_HZ / 1000;
    localparam logic [7:0] DEV = 8'h78;
    localparam int TW = 256 * 24;

    localparam logic [23:0] E_W1  = {16'h3008, 8'h82};
    localparam logic [23:0] E_DLY = {16'hFFFF, 8'h02};
    localparam logic [2:0][23:0] E_W3 = {24'h5001A5, 24'h30177F, 24'h310393};
    localparam logic [TW-1:0] T_W1  = {{(TW-24){1'b0}}, E_W1};
    localparam logic [TW-1:0] T_DLY = {{(TW-24){1'b0}}, E_DLY};
    localparam logic [TW-1:0] T_W3  = {{(TW-72){1'b0}}, E_W3};

    logic       clk;
    logic       rst;
    logic [2:0] start_w, busy_w, done_w, sioc_w, oe_w;
    logic [7:0] idx_w [3];
    int         sel;

    int checks, failures;
    logic [7:0] exp_bytes [$];
    int         exp_busy;
    logic [7:0] idx_seen [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ov5642_sccb_config #(.CLK_FREQ_HZ(CLK_HZ), .SCCB_FREQ_HZ(SCCB_HZ), .DEV_ADDR(DEV),
                         .TABLE_LEN(1), .TABLE_INIT(T_W1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .index(idx_w[0]), .sioc(sioc_w[0]), .siod_oe(oe_w[0]));

    ov5642_sccb_config #(.CLK_FREQ_HZ(CLK_HZ), .SCCB_FREQ_HZ(SCCB_HZ), .DEV_ADDR(DEV),
                         .TABLE_LEN(1), .TABLE_INIT(T_DLY)) u_dly (
        .clk(clk), .rst(rst), .start(start_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .index(idx_w[1]), .sioc(sioc_w[1]), .siod_oe(oe_w[1]));

    ov5642_sccb_config #(.CLK_FREQ_HZ(CLK_HZ), .SCCB_FREQ_HZ(SCCB_HZ), .DEV_ADDR(DEV),
                         .TABLE_LEN(3), .TABLE_INIT(T_W3)) u_w3 (
        .clk(clk), .rst(rst), .start(start_w[2]), .busy(busy_w[2]), .done(done_w[2]),
        .index(idx_w[2]), .sioc(sioc_w[2]), .siod_oe(oe_w[2]));

    // SCCB decoder on the selected instance: START/STOP by SIOD edges while SIOC high, bits on SIOC rise.
    logic       m_sioc, m_oe;
    logic [7:0] mon_bytes [$];
    int         mon_starts, mon_stops, mon_active, mon_min_gap, mon_stop_cyc, mon_cyc, nbits;
    logic [7:0] cur;
    bit         in_frame;
    logic       p_sioc, p_sda;

    assign m_sioc = sioc_w[sel];
    assign m_oe   = oe_w[sel];

    initial begin
        p_sioc = 1'b1; p_sda = 1'b1; mon_cyc = 0; cur = '0;
    end

    always @(negedge clk) begin
        logic sda;
        sda = ~m_oe;
        mon_cyc++;
        if (rst) begin
            in_frame = 1'b0;
        end else begin
            if (!(m_sioc && m_oe == 1'b0)) mon_active++;
            if (p_sioc && m_sioc && p_sda && !sda) begin
                if (mon_stops > 0 && (mon_cyc - mon_stop_cyc) < mon_min_gap) mon_min_gap = mon_cyc - mon_stop_cyc;
                in_frame = 1'b1;
                nbits = 0;
                mon_starts++;
            end else if (p_sioc && m_sioc && !p_sda && sda) begin
                in_frame = 1'b0;
                mon_stops++;
                mon_stop_cyc = mon_cyc;
            end else if (!p_sioc && m_sioc && in_frame) begin
                if (nbits < 36 && (nbits % 9) < 8) begin
                    cur = {cur[6:0], sda};
                    if ((nbits % 9) == 7) mon_bytes.push_back(cur);
                end
                nbits++;
            end
        end
        p_sioc = m_sioc;
        p_sda  = sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic mon_clear(input int w);
        @(posedge clk);
        #1;
        sel = w;
        mon_bytes.delete();
        mon_starts = 0; mon_stops = 0; mon_active = 0; nbits = 0;
        mon_min_gap = 1 << 30;
        in_frame = 1'b0;
    endtask

    // Transaction-level model: each entry's bus bytes and its contribution to the busy window.
    task automatic model_reset();
        exp_bytes.delete();
        exp_busy = 0;
    endtask

    task automatic model_entry(input logic [23:0] e, input bit last);
        if (e[23:8] == 16'hFFFF) begin
            exp_busy += 2 + int'(e[7:0]) * MS;
        end else begin
            exp_bytes.push_back(DEV);
            exp_bytes.push_back(e[23:16]);
            exp_bytes.push_back(e[15:8]);
            exp_bytes.push_back(e[7:0]);
            exp_busy += 2 + (2 + 4 * 9 * 4 + 3 + 4) * Q;
        end
        if (!last) exp_busy += 1;
    endtask

    task automatic pulse_start(input int w);
        @(negedge clk);
        start_w[w] = 1'b1;
        @(posedge clk);
        #1;
        start_w[w] = 1'b0;
    endtask

    task automatic run_to_done(input int w, output int cnt, output bit tmo);
        cnt = 0;
        tmo = 1'b1;
        idx_seen.delete();
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (busy_w[w]) begin
                cnt++;
                if (idx_seen.size() == 0 || idx_seen[$] != idx_w[w]) idx_seen.push_back(idx_w[w]);
            end else begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_bytes(input string tag);
        logic [7:0] ob;
        check({tag, "_nbytes"}, mon_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size(); i++) begin
            ob = 'x;
            if (i < mon_bytes.size()) ob = mon_bytes[i];
            check($sformatf("%s_byte%0d", tag, i), ob, exp_bytes[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag, input int w);
        check({tag, "_sioc"}, sioc_w[w], 1);
        check({tag, "_siod_oe"}, oe_w[w], 0);
        check({tag, "_busy"}, busy_w[w], 0);
        check({tag, "_done"}, done_w[w], 0);
        check({tag, "_index"}, idx_w[w], 0);
    endtask

    initial begin
        int  cnt, k, r;
        bit  tmo;
        checks = 0; failures = 0;
        sel = 0;
        start_w = '0;
        rst = 1'b1;
        #3;
        check_reset_outputs("rst0", 2);
        check_reset_outputs("rst0w1", 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single write entry: one transaction, fixed busy window, then done.
        mon_clear(0);
        model_reset();
        model_entry(E_W1, 1'b1);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        pulse_start(0);
        check("w1_busy_rise", busy_w[0], 1);
        run_to_done(0, cnt, tmo);
        check("w1_timeout", tmo, 0);
        check("w1_busy_cycles", cnt, exp_busy);
        check("w1_done", done_w[0], 1);
        check_bytes("w1");
        check("w1_starts", mon_starts, 1);
        check("w1_stops", mon_stops, 1);

        // Start while busy and again on the edge where done rises: both ignored.
        mon_clear(0);
        k = $urandom_range(50, 1400);
        pulse_start(0);
        for (int n = 1; n <= exp_busy; n++) begin
            @(negedge clk);
            start_w[0] = (n == k) || (n == exp_busy);
        end
        @(negedge clk);
        start_w[0] = 1'b0;
        check("ign_done_rise", done_w[0], 1);
        check("ign_busy_fall", busy_w[0], 0);
        repeat (200) @(negedge clk);
        check("ign_done_held", done_w[0], 1);
        check("ign_busy_low", busy_w[0], 0);
        check("ign_starts", mon_starts, 1);
        check_bytes("ign");

        // Delay-only entry: long quiet busy window, no bus activity.
        mon_clear(1);
        model_reset();
        model_entry(E_DLY, 1'b1);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        pulse_start(1);
        run_to_done(1, cnt, tmo);
        check("dly_timeout", tmo, 0);
        check("dly_busy_cycles", cnt, exp_busy);
        check("dly_done", done_w[1], 1);
        check("dly_bus_active", mon_active, 0);
        check("dly_starts", mon_starts, 0);

        // Three writes: ordered transactions, idle gap, index stepping.
        mon_clear(2);
        model_reset();
        for (int i = 0; i < 3; i++) model_entry(E_W3[i], i == 2);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        pulse_start(2);
        run_to_done(2, cnt, tmo);
        check("w3_timeout", tmo, 0);
        check("w3_busy_cycles", cnt, exp_busy);
        check("w3_done", done_w[2], 1);
        check_bytes("w3");
        check("w3_starts", mon_starts, 3);
        check("w3_stops", mon_stops, 3);
        check("w3_gap_ge40", mon_min_gap >= 40, 1);
        check("w3_nidx", idx_seen.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("w3_idx%0d", i), (i < idx_seen.size()) ? idx_seen[i] : 8'hxx, i);
        end

        // Reset in the middle of the second byte, then restart from entry 0.
        mon_clear(2);
        r = $urandom_range(400, 660);
        pulse_start(2);
        repeat (r) @(negedge clk);
        check("mid_in_byte2", mon_bytes.size(), 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst", 2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_clear(2);
        pulse_start(2);
        run_to_done(2, cnt, tmo);
        check("re_timeout", tmo, 0);
        check("re_busy_cycles", cnt, exp_busy);
        check("re_first_idx", (idx_seen.size() > 0) ? idx_seen[0] : 8'hxx, 0);
        check_bytes("re");
        check("re_done", done_w[2], 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
